jtdd_sndmix: RTL and testbench
==============================

// Module: jtdd_sndmix
// PURPOSE
//  Parametrised N-channel signed sound mixer replacing the fixed FM+ADPCM sum in the sound subsystems.
//  Snapshots all channels on each output-rate enable and applies a per-channel 4.4 gain and mute.
//  Accumulates one channel per clock through a single multiplier and saturates to the output width.
//  Flags clipping and enable overruns. Sits between the sound chips (jt51, jt6295, ...) and the frame audio output.
// PARAMETERS
//  CH    4   number of input channels (>=1)
//  WIN   16  signed width of every channel input; narrower sources are sign-extended or left-aligned by the user
//  WOUT  16  signed width of mixed output (WOUT <= WIN+4+clog2(CH))
// PORTS
//  clk      in   1        system clock (48 MHz)
//  rst      in   1        synchronous reset, active high
//  cen      in   1        output-sample strobe, one clk wide
//  ch_in    in   CH*WIN   channel k at [k*WIN +: WIN], signed two's complement
//  gain     in   CH*8     channel k gain at [k*8 +: 8], unsigned 4.4 fixed point (8'h10 = x1.0)
//  mute     in   CH       bit k=1 forces channel k to zero
//  sound    out  WOUT     mixed signed sample
//  sample   out  1        one-clk pulse: sound updated this cycle
//  clip     out  1        high with sample when the last mix saturated; holds until next sample
//  overrun  out  1        sticky: cen arrived while a mix was in progress
// BEHAVIOUR
//  Reset: sound=0, sample=0, clip=0, overrun=0, acc=0, idx=0, state=IDLE. Reset wins over every other event.
//  Reset mid-mix drops the mix with no sample pulse.
//  Accumulator width AW = WIN+8+clog2(CH)+1. All arithmetic is signed.
//  The product is the signed input times the unsigned gain, zero-extended to 9 bits.
//  States IDLE -> ACC -> OUT -> IDLE. Edge numbering below counts from the edge that samples cen=1.
//  IDLE: at edge E0 with cen=1: snapshot ch_in and gain into registers.
//    Snapshot value for channel k = mute[k] ? 0 : ch_in[k]. Clear acc, idx=0, go to ACC.
//  ACC: edges E1..ECH: acc <= acc + ((snap[idx]*gain[idx]) >>> 4). The shift is arithmetic (floor toward -inf).
//    Increment idx. After idx=CH-1, go to OUT.
//  OUT: edge E(CH+1): sound <= sat(acc), clip <= (acc out of WOUT range), sample <= 1 for exactly one cycle.
//    sat clamps to +2^(WOUT-1)-1 or -2^(WOUT-1). Go to IDLE.
//    A cen sampled at this same edge is accepted as a new E0: back-to-back operation, minimum cen period CH+1 clk.
//  Latency: sound/sample valid CH+1 clk edges after the cen edge.
//  Inputs may change freely after E0; only the snapshot is used.
//  A cen sampled in ACC is ignored and sets overrun (sticky until rst). The mix in progress completes unaffected.
//  sample is 0 in every cycle except the one following the OUT edge. sound and clip hold between samples.
//  CH=1 is legal: one ACC cycle, latency 2.
// TESTING
//  1 CH=4, gains 8'h10, inputs 1000,-200,300,0; pulse cen -> after 5 edges sound=1100, sample pulses once, clip=0.
//  2 gain 8'h18 on ch0=1000, others muted via mute=4'b1110 with nonzero inputs -> sound=1500.
//    Then gain 8'h08, ch0=-3 -> sound=-2 (floor).
//  3 all four inputs 32767, gain 8'hFF -> sound=32767, clip=1.
//    All inputs -32768, gain 8'hFF -> sound=-32768, clip=1. Next normal mix clears clip.
//  4 cen every 5 clk for 100 samples -> 100 sample pulses, overrun=0.
//    cen 2 clk after the previous one -> ignored, overrun=1 and stays 1, first mix result still correct.
//  5 change ch_in on the clock after cen -> output reflects the old snapshot.
//    Assert rst during ACC -> no sample pulse; sound=0, clip=0, overrun=0 next cycle.
//    cen right after rst release mixes normally.

Source files
------------

// File: rtl/jtdd_sndmix.sv
// ============================================================================
//  Module      : jtdd_sndmix
//  Description : N-channel signed sound mixer. Snapshots every channel on the
//                output-rate strobe. Each channel is scaled by a 4.4 gain or
//                muted. The channels are summed one per clock through a single
//                multiplier. The sum is saturated to the output width, and
//                clipping and strobe overruns are flagged.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module jtdd_sndmix #(
    parameter int CH   = 4,
    parameter int WIN  = 16,
    parameter int WOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cen,
    input  logic [CH*WIN-1:0]      ch_in,
    input  logic [CH*8-1:0]        gain,
    input  logic [CH-1:0]          mute,
    output logic signed [WOUT-1:0] sound,
    output logic                   sample,
    output logic                   clip,
    output logic                   overrun
);

    // The accumulator holds CH products of WIN x 9 bits after the >>>4.
    // One extra bit is kept as headroom.
    localparam int c_aw = WIN + 8 + $clog2(CH) + 1;
    localparam int c_iw = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [c_iw-1:0]        c_last = c_iw'(CH - 1);
    localparam logic signed [WOUT-1:0] c_max  = {1'b0, {(WOUT-1){1'b1}}};
    localparam logic signed [WOUT-1:0] c_min  = {1'b1, {(WOUT-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic signed [c_aw-1:0]   acc_q, acc_d;
    logic [c_iw-1:0]          idx_q, idx_d;
    logic signed [WIN-1:0]    snap_q [CH];
    logic signed [WIN-1:0]    snap_d [CH];
    logic [7:0]               gsnap_q [CH];
    logic [7:0]               gsnap_d [CH];
    logic signed [WOUT-1:0]   sound_q, sound_d;
    logic                     sample_q, sample_d;
    logic                     clip_q, clip_d;
    logic                     overrun_q, overrun_d;

    logic signed [WIN+8:0]    w_prod;
    logic signed [c_aw-1:0]   w_term;
    logic [c_aw-WOUT:0]       w_hi;
    logic                     w_ovf;
    logic signed [WOUT-1:0]   w_sat;
    logic                     w_take;

    // The gain is unsigned, so it is zero-extended before the signed multiply.
    // The arithmetic shift then rounds the 4.4 product toward minus infinity.
    assign w_prod = snap_q[idx_q] * $signed({1'b0, gsnap_q[idx_q]});
    assign w_term = c_aw'(w_prod >>> 4);

    // The sum fits WOUT only when every bit above the output sign bit copies it.
    assign w_hi   = acc_q[c_aw-1:WOUT-1];
    assign w_ovf  = ~((&w_hi) | ~(|w_hi));
    assign w_sat  = w_ovf ? (acc_q[c_aw-1] ? c_min : c_max) : acc_q[WOUT-1:0];

    // A new strobe is accepted when idle, and also on the output edge so that
    // back-to-back mixes can run.
    assign w_take = cen && (state_q == ST_IDLE || state_q == ST_OUT);

    // Next-state logic for the IDLE -> ACC -> OUT sequence.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        gsnap_d   = gsnap_q;
        sound_d   = sound_q;
        sample_d  = 1'b0;
        clip_d    = clip_q;
        overrun_d = overrun_q;

        case (state_q)
            ST_ACC: begin
                acc_d = acc_q + w_term;
                if (cen) begin
                    overrun_d = 1'b1;
                end
                if (idx_q == c_last) begin
                    state_d = ST_OUT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_OUT: begin
                sound_d  = w_sat;
                clip_d   = w_ovf;
                sample_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: ;
        endcase

        if (w_take) begin
            for (int k = 0; k < CH; k++) begin
                snap_d[k]  = mute[k] ? '0 : ch_in[k*WIN +: WIN];
                gsnap_d[k] = gain[k*8 +: 8];
            end
            acc_d   = '0;
            idx_d   = '0;
            state_d = ST_ACC;
        end
    end

    // State registers. Reset clears everything and drops any mix in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            idx_q     <= '0;
            for (int k = 0; k < CH; k++) begin
                snap_q[k]  <= '0;
                gsnap_q[k] <= '0;
            end
            sound_q   <= '0;
            sample_q  <= 1'b0;
            clip_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            gsnap_q   <= gsnap_d;
            sound_q   <= sound_d;
            sample_q  <= sample_d;
            clip_q    <= clip_d;
            overrun_q <= overrun_d;
        end
    end

    assign sound   = sound_q;
    assign sample  = sample_q;
    assign clip    = clip_q;
    assign overrun = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_jtdd_sndmix.sv
// ============================================================================
//  Module      : tb_jtdd_sndmix
//  Description : Self-checking bench for jtdd_sndmix (CH=4, WIN=16, WOUT=16).
//                A table of directed mixes is followed by hand-written
//                sequences for back-to-back operation, overrun, snapshot
//                isolation and reset during a mix.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_jtdd_sndmix;

    localparam int CH   = 4;
    localparam int WIN  = 16;
    localparam int WOUT = 16;

    logic                   clk;
    logic                   rst;
    logic                   cen;
    logic [CH*WIN-1:0]      ch_in;
    logic [CH*8-1:0]        gain;
    logic [CH-1:0]          mute;
    logic signed [WOUT-1:0] sound;
    logic                   sample;
    logic                   clip;
    logic                   overrun;

    int checks   = 0;
    int failures = 0;

    jtdd_sndmix #(
        .CH   (CH),
        .WIN  (WIN),
        .WOUT (WOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cen     (cen),
        .ch_in   (ch_in),
        .gain    (gain),
        .mute    (mute),
        .sound   (sound),
        .sample  (sample),
        .clip    (clip),
        .overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [CH*WIN-1:0] chv;
        logic [CH*8-1:0]   gv;
        logic [CH-1:0]     m;
        int                exp_s;
        bit                exp_c;
        string             name;
    } vec_t;

    // Channel 0 is the first argument.
    function automatic logic [63:0] p4(input int c0, input int c1, input int c2, input int c3);
        return {c3[15:0], c2[15:0], c1[15:0], c0[15:0]};
    endfunction

    function automatic logic [31:0] g4(input int g0, input int g1, input int g2, input int g3);
        return {g3[7:0], g2[7:0], g1[7:0], g0[7:0]};
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Strobe cen once and watch 8 edges. Exactly one sample pulse must appear,
    // at edge 5, carrying the expected sound and clip.
    task automatic run_mix(input vec_t v);
        int first;
        int pulses;
        int s_at;
        int c_at;
        first  = -1;
        pulses = 0;
        s_at   = 0;
        c_at   = 0;
        @(negedge clk);
        ch_in = v.chv;
        gain  = v.gv;
        mute  = v.m;
        cen   = 1'b1;
        @(posedge clk);
        #1 cen = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            if (sample) begin
                pulses++;
                if (first < 0) begin
                    first = e;
                    s_at  = int'(sound);
                    c_at  = int'(clip);
                end
            end
        end
        check({v.name, " latency"}, first, CH + 1);
        check({v.name, " pulses"}, pulses, 1);
        check({v.name, " sound"}, s_at, v.exp_s);
        check({v.name, " clip"}, c_at, int'(v.exp_c));
    endtask

    vec_t vt [10];
    vec_t base;
    vec_t other;

    initial begin
        int pulses;
        int s_at;

        vt[0] = '{p4(1000, -200, 300, 0), g4('h10, 'h10, 'h10, 'h10), 4'b0000, 1100, 1'b0, "unity"};
        vt[1] = '{p4(1000, 5000, 6000, 7000), g4('h18, 'h10, 'h10, 'h10), 4'b1110, 1500, 1'b0, "gain1p5_mute"};
        vt[2] = '{p4(-3, 5000, 6000, 7000), g4('h08, 'h10, 'h10, 'h10), 4'b1110, -2, 1'b0, "floor"};
        vt[3] = '{p4(32767, 32767, 32767, 32767), g4('hFF, 'hFF, 'hFF, 'hFF), 4'b0000, 32767, 1'b1, "clip_pos"};
        vt[4] = '{p4(-32768, -32768, -32768, -32768), g4('hFF, 'hFF, 'hFF, 'hFF), 4'b0000, -32768, 1'b1, "clip_neg"};
        vt[5] = '{p4(100, 200, 300, 400), g4('h10, 'h10, 'h10, 'h10), 4'b0000, 1000, 1'b0, "clip_clear"};
        vt[6] = '{p4(100, -50, 7, -1), g4('h20, 'h08, 'h01, 'h01), 4'b0000, 174, 1'b0, "mixed_gain"};
        vt[7] = '{p4(16383, 16384, 0, 0), g4('h10, 'h10, 'h10, 'h10), 4'b0000, 32767, 1'b0, "max_exact"};
        vt[8] = '{p4(16384, 16384, 0, 0), g4('h10, 'h10, 'h10, 'h10), 4'b0000, 32767, 1'b1, "max_plus1"};
        vt[9] = '{p4(-16384, -16384, 0, 0), g4('h10, 'h10, 'h10, 'h10), 4'b0000, -32768, 1'b0, "min_exact"};
        base  = vt[0];
        other = '{p4(-7000, 123, 4000, -9), g4('h30, 'h10, 'h10, 'h10), 4'b0000, 0, 1'b0, "unused"};

        rst   = 1'b1;
        cen   = 1'b0;
        ch_in = '0;
        gain  = '0;
        mute  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset sound", int'(sound), 0);
        check("reset sample", int'(sample), 0);
        check("reset clip", int'(clip), 0);
        check("reset overrun", int'(overrun), 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed mix table.
        for (int i = 0; i < 10; i++) begin
            run_mix(vt[i]);
        end
        check("table overrun", int'(overrun), 0);

        // Back-to-back operation with cen every 5 clocks for 100 samples.
        ch_in  = base.chv;
        gain   = base.gv;
        mute   = base.m;
        pulses = 0;
        for (int cyc = 0; cyc < 510; cyc++) begin
            @(negedge clk);
            cen = (cyc % 5 == 0) && (cyc < 500);
            @(posedge clk);
            #1;
            if (sample) pulses++;
        end
        cen = 1'b0;
        check("b2b pulses", pulses, 100);
        check("b2b overrun", int'(overrun), 0);
        check("b2b sound", int'(sound), 1100);

        // Inputs changed right after the strobe must not affect the result.
        @(negedge clk);
        ch_in = base.chv;
        gain  = base.gv;
        mute  = base.m;
        cen   = 1'b1;
        @(posedge clk);
        #1 cen = 1'b0;
        ch_in = other.chv;
        gain  = other.gv;
        s_at  = -99999;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1;
            if (sample) s_at = int'(sound);
        end
        check("snapshot sound", s_at, 1100);

        // A second cen two clocks into the mix is ignored and sets overrun.
        @(negedge clk);
        ch_in = base.chv;
        gain  = base.gv;
        mute  = base.m;
        cen   = 1'b1;
        @(posedge clk);
        #1 cen = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cen = 1'b1;
        @(posedge clk);
        #1 cen = 1'b0;
        pulses = 0;
        s_at   = -99999;
        for (int e = 3; e <= 12; e++) begin
            @(posedge clk);
            #1;
            if (sample) begin
                pulses++;
                if (e != 5) check("overrun pulse edge", e, 5);
                s_at = int'(sound);
            end
        end
        check("overrun pulses", pulses, 1);
        check("overrun sound", s_at, 1100);
        check("overrun flag", int'(overrun), 1);
        run_mix(vt[5]);
        check("overrun sticky", int'(overrun), 1);

        // Reset in the middle of accumulation drops the mix.
        @(negedge clk);
        ch_in = base.chv;
        gain  = base.gv;
        mute  = base.m;
        cen   = 1'b1;
        @(posedge clk);
        #1 cen = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst sound", int'(sound), 0);
        check("midrst clip", int'(clip), 0);
        check("midrst overrun", int'(overrun), 0);
        check("midrst sample", int'(sample), 0);
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk);
            #1;
            if (sample) pulses++;
        end
        check("midrst pulses", pulses, 0);

        // A strobe on the first edge after reset release mixes normally.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_mix(vt[6]);
        check("post rst overrun", int'(overrun), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
